// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache between the fetch
// port (ibus) and the shared cached bus (cbus).
//   clk, resetn : clock, synchronous active-low reset
//   ireq/iresp  : fetch request {valid, addr} / response {addr_ok, data_ok, data}
//   creq/cresp  : line-refill / uncached read request and bus response
//   flush       : one-cycle pulse, invalidates every line
// Optional build macro ICACHE_STATS_EN adds hit_cnt / miss_cnt outputs.

package icache_dm_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int unsigned OFFSET_BITS = 4,
    parameter int unsigned INDEX_BITS  = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp,
    input  logic       flush
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned WORDS   = 1 << (OFFSET_BITS - 2);
    localparam int unsigned LINES   = 1 << INDEX_BITS;
    localparam int unsigned TAG_LSB = OFFSET_BITS + INDEX_BITS;
    localparam int unsigned TAG_W   = 32 - TAG_LSB;
    localparam int unsigned IDX_MSB = TAG_LSB - 1;
    localparam int unsigned DA_W    = INDEX_BITS + OFFSET_BITS - 2;
    localparam int unsigned CNT_W   = OFFSET_BITS - 1;
    localparam logic [31:0] LINE_MASK = 32'((1 << OFFSET_BITS) - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REFILL   = 2'd1,
        S_UNCACHED = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES*WORDS];
    logic [31:0]        req_addr;
    logic [CNT_W-1:0]   count;
    logic               flush_pending;
    logic               byp_valid;
    logic [31:0]        byp_addr;
    logic [31:0]        byp_data;

    logic [INDEX_BITS-1:0] req_idx, line_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [DA_W-1:0]       rd_ptr, wr_ptr;
    logic                  uncached, hit, byp_hit, beat_last;

    // Address decode; data array is flat, addressed by {index, word offset}.
    assign req_idx   = ireq.addr[IDX_MSB:OFFSET_BITS];
    assign req_tag   = ireq.addr[31:TAG_LSB];
    assign rd_ptr    = ireq.addr[IDX_MSB:2];
    assign uncached  = (ireq.addr[31:29] == 3'b101);
    assign line_idx  = req_addr[IDX_MSB:OFFSET_BITS];
    assign wr_ptr    = DA_W'(req_addr >> 2) | DA_W'(count);
    assign beat_last = cresp.ready && cresp.last;

    assign hit     = (state == S_IDLE) && ireq.valid && !uncached
                     && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign byp_hit = (state == S_IDLE) && ireq.valid && uncached
                     && byp_valid && (byp_addr == ireq.addr);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_d;
    end

    // Next state, fetch response and bus request
    always_comb begin
        state_d    = state;
        iresp      = '0;
        creq       = '0;
        creq.size  = MSIZE4;
        creq.burst = AXI_BURST_INCR;
        creq.addr  = req_addr;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    iresp.addr_ok = 1'b1;
                    iresp.data_ok = 1'b1;
                    iresp.data    = data_mem[rd_ptr];
                end else if (byp_hit) begin
                    iresp.addr_ok = 1'b1;
                    iresp.data_ok = 1'b1;
                    iresp.data    = byp_data;
                end else if (ireq.valid) begin
                    state_d = uncached ? S_UNCACHED : S_REFILL;
                end
            end
            S_REFILL: begin
                creq.valid = 1'b1;
                creq.len   = 8'(WORDS - 1);
                if (beat_last) state_d = S_IDLE;
            end
            S_UNCACHED: begin
                creq.valid = 1'b1;
                if (beat_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valid bits, refill bookkeeping and the one-shot uncached bypass register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q       <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
            req_addr      <= '0;
            byp_valid     <= 1'b0;
            byp_addr      <= '0;
            byp_data      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    flush_pending <= 1'b0;
                    if (flush) valid_q <= '0;
                    if (byp_hit) byp_valid <= 1'b0;
                    if (state_d == S_REFILL) begin
                        // Line is rewritten in place, so drop it until the refill lands.
                        valid_q[req_idx] <= 1'b0;
                        req_addr         <= ireq.addr & ~LINE_MASK;
                        count            <= '0;
                    end
                    if (state_d == S_UNCACHED) begin
                        req_addr <= ireq.addr & ~32'h3;
                        byp_addr <= ireq.addr;
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                        valid_q       <= '0;
                    end
                    if (cresp.ready) count <= count + CNT_W'(1);
                    if (beat_last) begin
                        count <= '0;
                        // A flush seen during the burst leaves the line invalid.
                        if (!flush_pending && !flush) valid_q[line_idx] <= 1'b1;
                    end
                end
                S_UNCACHED: begin
                    if (beat_last) begin
                        byp_valid <= 1'b1;
                        byp_data  <= cresp.data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data register arrays, written one word per accepted refill beat
    always_ff @(posedge clk) begin
        if (resetn && (state == S_REFILL) && cresp.ready) begin
            data_mem[wr_ptr] <= cresp.data;
            if (cresp.last) tag_mem[line_idx] <= req_addr[31:TAG_LSB];
        end
    end

`ifdef ICACHE_STATS_EN
    // Hit/miss statistics; wrap naturally and survive flush
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) hit_cnt <= hit_cnt + 32'd1;
            if ((state == S_IDLE) && (state_d == S_REFILL)) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: self-checking bench for icache_dm (default parameters, W=4).
// A bus model serves creq from a fixed memory function; fetch results are
// compared against a vector table, hand-written corner sequences and a
// line-level valid/tag reference model under random fetches.

module tb_icache_dm;
    import icache_dm_pkg::*;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       flush  = 1'b0;
    ibus_req_t  ireq   = '0;
    ibus_resp_t iresp;
    cbus_req_t  creq;
    cbus_resp_t cresp  = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    icache_dm dut (
        .clk     (clk),
        .resetn  (resetn),
        .ireq    (ireq),
        .iresp   (iresp),
        .creq    (creq),
        .cresp   (cresp),
        .flush   (flush)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Backing memory seen through the bus
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h8000_0010: return 32'h0000_0011;
            32'h8000_0014: return 32'h0000_0022;
            32'h8000_0018: return 32'h0000_0033;
            32'h8000_001C: return 32'h0000_0044;
            32'hBFC0_0000: return 32'h3C08_BFC0;
            default:       return {a[15:0], 16'hC0DE} ^ {16'h0, a[31:16]};
        endcase
    endfunction

    // Bus model: beat tracking and burst log
    int          beat        = 0;
    int          bursts      = 0;
    int          writes_seen = 0;
    logic [31:0] last_baddr  = '0;
    logic [7:0]  last_blen   = '0;
    bit          stall_en    = 1'b0;

    always @(posedge clk) begin
        if (!resetn) begin
            beat <= 0;
        end else if (creq.valid && cresp.ready) begin
            if (creq.is_write) writes_seen <= writes_seen + 1;
            if (cresp.last) begin
                beat       <= 0;
                bursts     <= bursts + 1;
                last_baddr <= creq.addr;
                last_blen  <= creq.len;
            end else begin
                beat <= beat + 1;
            end
        end
    end

    always @(negedge clk) begin
        cresp.ready = creq.valid && (!stall_en || ($urandom_range(3) != 0));
        cresp.data  = mem(creq.addr + 32'(beat * 4));
        cresp.last  = (beat == int'(creq.len));
    end

    // Present a request and hold it until addr_ok; flush optionally pulsed in the first cycle
    task automatic fetch(input logic [31:0] a, input bit fl,
                         output logic [31:0] d, output int lat, output int nb);
        bit got;
        int b0;
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        flush      = fl;
        b0  = bursts;
        lat = 0;
        d   = '0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            #1;
            if (iresp.addr_ok) begin
                got = 1'b1;
                d   = iresp.data;
                check("data_ok", 32'(iresp.data_ok), 32'd1);
            end else begin
                lat++;
                @(negedge clk);
                flush = 1'b0;
            end
        end
        nb = bursts - b0;
        check("response_timeout", 32'(got), 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        ireq.valid = 1'b0;
        flush      = 1'b0;
    endtask

    // Wait for the second beat of the current burst to be on the bus
    task automatic wait_beat2(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (beat == 1) && creq.valid;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          nb;
        logic [31:0] baddr;
        logic [7:0]  blen;
    } vec_t;

    vec_t vecs[8];

    bit          mv [64];
    logic [21:0] mt [64];

    initial begin
        logic [31:0] d;
        int          lat, nb;

        vecs[0] = '{32'h8000_0010, 32'h11,        5, 1, 32'h8000_0010, 8'd3};
        vecs[1] = '{32'h8000_0014, 32'h22,        0, 0, 32'h0,         8'd0};
        vecs[2] = '{32'h8000_0018, 32'h33,        0, 0, 32'h0,         8'd0};
        vecs[3] = '{32'h8000_001C, 32'h44,        0, 0, 32'h0,         8'd0};
        vecs[4] = '{32'h8000_0410, mem(32'h8000_0410), 5, 1, 32'h8000_0410, 8'd3};
        vecs[5] = '{32'h8000_0010, 32'h11,        5, 1, 32'h8000_0010, 8'd3};
        vecs[6] = '{32'hBFC0_0000, 32'h3C08_BFC0, 2, 1, 32'hBFC0_0000, 8'd0};
        vecs[7] = '{32'hBFC0_0000, 32'h3C08_BFC0, 2, 1, 32'hBFC0_0000, 8'd0};

        // Reset state
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_creq_valid", 32'(creq.valid), 32'd0);
        check("rst_addr_ok",    32'(iresp.addr_ok), 32'd0);
        check("rst_data_ok",    32'(iresp.data_ok), 32'd0);
        check("rst_data",       iresp.data, 32'd0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_cnt",  hit_cnt,  32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        resetn = 1'b1;

        // Cold miss, back-to-back hits, conflict miss, uncached bypass
        for (int i = 0; i < 8; i++) begin
            fetch(vecs[i].addr, 1'b0, d, lat, nb);
            check($sformatf("vec%0d_data", i), d, vecs[i].data);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_bursts", i), 32'(nb), 32'(vecs[i].nb));
            if (vecs[i].nb == 0) begin
                check($sformatf("vec%0d_creq_idle", i), 32'(creq.valid), 32'd0);
            end else begin
                check($sformatf("vec%0d_baddr", i), last_baddr, vecs[i].baddr);
                check($sformatf("vec%0d_blen", i), 32'(last_blen), 32'(vecs[i].blen));
            end
`ifdef ICACHE_STATS_EN
            if (i == 3) begin
                idle();
                #1;
                check("stats_hit_cnt",  hit_cnt,  32'd4);
                check("stats_miss_cnt", miss_cnt, 32'd1);
            end
`endif
        end

        // Flush during beat 2 of a refill: burst completes, line refetched
        begin
            bit got = 1'b0;
            int b0;
            @(negedge clk);
            ireq.valid = 1'b1;
            ireq.addr  = 32'h8000_0020;
            flush      = 1'b0;
            b0 = bursts;
            wait_beat2("flush_beat2_seen");
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                #1;
                if (iresp.addr_ok) got = 1'b1;
                else @(negedge clk);
            end
            check("flush_resp_seen", 32'(got), 32'd1);
            check("flush_bursts", 32'(bursts - b0), 32'd2);
            check("flush_baddr", last_baddr, 32'h8000_0020);
            check("flush_data", iresp.data, mem(32'h8000_0020));
        end

        // Reset pulse during beat 2 of a refill
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = 32'h8000_0030;
        wait_beat2("reset_beat2_seen");
        resetn = 1'b0;
        @(negedge clk);
        resetn     = 1'b1;
        ireq.valid = 1'b0;
        #1;
        check("reset_creq_valid", 32'(creq.valid), 32'd0);
        check("reset_addr_ok",    32'(iresp.addr_ok), 32'd0);
        fetch(32'h8000_0010, 1'b0, d, lat, nb);
        check("after_reset_bursts_10", 32'(nb), 32'd1);
        check("after_reset_data_10", d, 32'h11);
        fetch(32'h8000_0020, 1'b0, d, lat, nb);
        check("after_reset_bursts_20", 32'(nb), 32'd1);
        check("after_reset_data_20", d, mem(32'h8000_0020));

        // Randomized fetches against a line-level reference model
        @(negedge clk);
        ireq.valid = 1'b0;
        flush      = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        stall_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            bit          unc, fl, exp_hit;
            int          idx;
            logic [21:0] tag;
            unc = ($urandom_range(9) == 0);
            fl  = ($urandom_range(9) == 0);
            if (unc) a = 32'hBFC0_0000 + 32'($urandom_range(7) * 4) + 32'($urandom_range(3));
            else     a = 32'h8000_0000 + 32'($urandom_range(2) * 1024) + 32'($urandom_range(3) * 16)
                         + 32'($urandom_range(3) * 4) + 32'($urandom_range(3));
            idx = int'(a[9:4]);
            tag = a[31:10];
            exp_hit = !unc && mv[idx] && (mt[idx] == tag);
            if ($urandom_range(4) == 0) idle();
            fetch(a, fl, d, lat, nb);
            check($sformatf("rnd%0d_data", n), d, mem({a[31:2], 2'b00}));
            check($sformatf("rnd%0d_bursts", n), 32'(nb), exp_hit ? 32'd0 : 32'd1);
            if (exp_hit) check($sformatf("rnd%0d_lat", n), 32'(lat), 32'd0);
            if (fl) begin
                for (int i = 0; i < 64; i++) mv[i] = 1'b0;
            end
            if (!unc && !exp_hit) begin
                mv[idx] = 1'b1;
                mt[idx] = tag;
            end
        end
        idle();
        stall_en = 1'b0;
        repeat (2) @(negedge clk);

        check("no_writes", 32'(writes_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
